// File: rtl/l2tlb_l1port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// l2tlb_l1port : L2 TLB port for one L1 TLB (lookup/ack, fill, eviction snoop)
// Revision 1.0
// ---------------------------------------------------------------------------
module l2tlb_l1port #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 28,
  parameter int PPN_W   = 28,
  parameter int ID_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l1tlbtol2tlb_req_valid,
  output logic             l1tlbtol2tlb_req_retry,
  input  logic [VPN_W-1:0] l1tlbtol2tlb_req_vpn,
  input  logic [ID_W-1:0]  l1tlbtol2tlb_req_id,
  output logic             l2tlbtol1tlb_ack_valid,
  input  logic             l2tlbtol1tlb_ack_retry,
  output logic [ID_W-1:0]  l2tlbtol1tlb_ack_id,
  output logic             l2tlbtol1tlb_ack_hit,
  output logic [PPN_W-1:0] l2tlbtol1tlb_ack_ppn,
  input  logic             ptwtol2tlb_fill_valid,
  output logic             ptwtol2tlb_fill_retry,
  input  logic [VPN_W-1:0] ptwtol2tlb_fill_vpn,
  input  logic [PPN_W-1:0] ptwtol2tlb_fill_ppn,
  output logic             l2tlbtol1tlb_snoop_valid,
  input  logic             l2tlbtol1tlb_snoop_retry,
  output logic [VPN_W-1:0] l2tlbtol1tlb_snoop_vpn,
  input  logic             l1tlbtol2tlb_sack_valid,
  output logic             l1tlbtol2tlb_sack_retry,
  output logic             sack_err
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SNOOP = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [ENTRIES-1:0] valid_q;
  logic [VPN_W-1:0]   vpn_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  logic [IDX_W-1:0]   victim_ptr_q, victim_ptr_d;
  logic [1:0]         state_q, state_d;
  logic [VPN_W-1:0]   snoop_vpn_q, snoop_vpn_d;
  logic               ack_valid_q, ack_valid_d;
  logic [ID_W-1:0]    ack_id_q, ack_id_d;
  logic               ack_hit_q, ack_hit_d;
  logic [PPN_W-1:0]   ack_ppn_q, ack_ppn_d;
  logic               sack_err_q, sack_err_d;

  logic               req_accept, ack_xfer, fill_accept, evict;
  logic               lk_hit;
  logic [PPN_W-1:0]   lk_ppn;
  logic               fm_hit, inv_found;
  logic [IDX_W-1:0]   fm_idx, inv_idx, tgt_idx;

  assign l1tlbtol2tlb_req_retry  = ack_valid_q & l2tlbtol1tlb_ack_retry;
  assign req_accept              = l1tlbtol2tlb_req_valid & ~l1tlbtol2tlb_req_retry;
  assign ack_xfer                = ack_valid_q & ~l2tlbtol1tlb_ack_retry;
  assign ptwtol2tlb_fill_retry   = (state_q != ST_IDLE);
  assign fill_accept             = ptwtol2tlb_fill_valid & ~ptwtol2tlb_fill_retry;
  assign l1tlbtol2tlb_sack_retry = 1'b0;

  assign l2tlbtol1tlb_ack_valid   = ack_valid_q;
  assign l2tlbtol1tlb_ack_id      = ack_id_q;
  assign l2tlbtol1tlb_ack_hit     = ack_hit_q;
  assign l2tlbtol1tlb_ack_ppn     = ack_ppn_q;
  assign l2tlbtol1tlb_snoop_valid = (state_q == ST_SNOOP);
  assign l2tlbtol1tlb_snoop_vpn   = snoop_vpn_q;
  assign sack_err                 = sack_err_q;

  // Lookup always uses start-of-cycle array contents, so a same-cycle fill is not visible.
  always_comb begin
    lk_hit = 1'b0;
    lk_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == l1tlbtol2tlb_req_vpn)) begin
        lk_hit = 1'b1;
        lk_ppn = ppn_q[i];
      end
    end
  end

  // Fill target: matching entry, else lowest invalid entry, else round-robin victim.
  always_comb begin
    fm_hit    = 1'b0;
    fm_idx    = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == ptwtol2tlb_fill_vpn)) begin
        fm_hit = 1'b1;
        fm_idx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
    evict   = ~fm_hit & ~inv_found;
    tgt_idx = fm_hit ? fm_idx : (inv_found ? inv_idx : victim_ptr_q);
  end

  always_comb begin
    state_d      = state_q;
    victim_ptr_d = victim_ptr_q;
    snoop_vpn_d  = snoop_vpn_q;
    ack_valid_d  = ack_valid_q;
    ack_id_d     = ack_id_q;
    ack_hit_d    = ack_hit_q;
    ack_ppn_d    = ack_ppn_q;
    sack_err_d   = sack_err_q | (l1tlbtol2tlb_sack_valid & (state_q != ST_WAIT));

    if (req_accept) begin
      ack_valid_d = 1'b1;
      ack_id_d    = l1tlbtol2tlb_req_id;
      ack_hit_d   = lk_hit;
      ack_ppn_d   = lk_ppn;
    end else if (ack_xfer) begin
      ack_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fill_accept && evict) begin
          state_d      = ST_SNOOP;
          snoop_vpn_d  = vpn_q[victim_ptr_q];
          victim_ptr_d = victim_ptr_q + IDX_W'(1);
        end
      end
      ST_SNOOP: if (!l2tlbtol1tlb_snoop_retry) state_d = ST_WAIT;
      ST_WAIT:  if (l1tlbtol2tlb_sack_valid)   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      victim_ptr_q <= '0;
      state_q      <= ST_IDLE;
      snoop_vpn_q  <= '0;
      ack_valid_q  <= 1'b0;
      ack_id_q     <= '0;
      ack_hit_q    <= 1'b0;
      ack_ppn_q    <= '0;
      sack_err_q   <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_q[i] <= '0;
        ppn_q[i] <= '0;
      end
    end else begin
      victim_ptr_q <= victim_ptr_d;
      state_q      <= state_d;
      snoop_vpn_q  <= snoop_vpn_d;
      ack_valid_q  <= ack_valid_d;
      ack_id_q     <= ack_id_d;
      ack_hit_q    <= ack_hit_d;
      ack_ppn_q    <= ack_ppn_d;
      sack_err_q   <= sack_err_d;
      if (fill_accept) begin
        valid_q[tgt_idx] <= 1'b1;
        vpn_q[tgt_idx]   <= ptwtol2tlb_fill_vpn;
        ppn_q[tgt_idx]   <= ptwtol2tlb_fill_ppn;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2tlb_l1port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_l2tlb_l1port : directed self-checking bench for l2tlb_l1port
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_l2tlb_l1port;

  localparam int VPN_W = 28;
  localparam int PPN_W = 28;
  localparam int ID_W  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_retry;
  logic [VPN_W-1:0] req_vpn;
  logic [ID_W-1:0]  req_id;
  logic             ack_valid, ack_retry, ack_hit;
  logic [ID_W-1:0]  ack_id;
  logic [PPN_W-1:0] ack_ppn;
  logic             fill_valid, fill_retry;
  logic [VPN_W-1:0] fill_vpn;
  logic [PPN_W-1:0] fill_ppn;
  logic             snoop_valid, snoop_retry;
  logic [VPN_W-1:0] snoop_vpn;
  logic             sack_valid, sack_retry, sack_err;

  int n_cmp = 0;
  int n_err = 0;

  l2tlb_l1port #(.ENTRIES(8), .VPN_W(VPN_W), .PPN_W(PPN_W), .ID_W(ID_W)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .l1tlbtol2tlb_req_valid   (req_valid),
    .l1tlbtol2tlb_req_retry   (req_retry),
    .l1tlbtol2tlb_req_vpn     (req_vpn),
    .l1tlbtol2tlb_req_id      (req_id),
    .l2tlbtol1tlb_ack_valid   (ack_valid),
    .l2tlbtol1tlb_ack_retry   (ack_retry),
    .l2tlbtol1tlb_ack_id      (ack_id),
    .l2tlbtol1tlb_ack_hit     (ack_hit),
    .l2tlbtol1tlb_ack_ppn     (ack_ppn),
    .ptwtol2tlb_fill_valid    (fill_valid),
    .ptwtol2tlb_fill_retry    (fill_retry),
    .ptwtol2tlb_fill_vpn      (fill_vpn),
    .ptwtol2tlb_fill_ppn      (fill_ppn),
    .l2tlbtol1tlb_snoop_valid (snoop_valid),
    .l2tlbtol1tlb_snoop_retry (snoop_retry),
    .l2tlbtol1tlb_snoop_vpn   (snoop_vpn),
    .l1tlbtol2tlb_sack_valid  (sack_valid),
    .l1tlbtol2tlb_sack_retry  (sack_retry),
    .sack_err                 (sack_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ack(input string tag, input logic [ID_W-1:0] id,
                         input logic hit, input logic [PPN_W-1:0] ppn);
    chk({tag, "_valid"}, 64'(ack_valid), 64'(1));
    chk({tag, "_id"},    64'(ack_id),    64'(id));
    chk({tag, "_hit"},   64'(ack_hit),   64'(hit));
    chk({tag, "_ppn"},   64'(ack_ppn),   64'(ppn));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack_valid"},   64'(ack_valid),   64'(0));
    chk({tag, "_ack_hit"},     64'(ack_hit),     64'(0));
    chk({tag, "_ack_ppn"},     64'(ack_ppn),     64'(0));
    chk({tag, "_ack_id"},      64'(ack_id),      64'(0));
    chk({tag, "_req_retry"},   64'(req_retry),   64'(0));
    chk({tag, "_fill_retry"},  64'(fill_retry),  64'(0));
    chk({tag, "_snoop_valid"}, 64'(snoop_valid), 64'(0));
    chk({tag, "_snoop_vpn"},   64'(snoop_vpn),   64'(0));
    chk({tag, "_sack_retry"},  64'(sack_retry),  64'(0));
    chk({tag, "_sack_err"},    64'(sack_err),    64'(0));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_vpn = '0; req_id = '0; ack_retry = 1'b0;
    fill_valid = 1'b0; fill_vpn = '0; fill_ppn = '0;
    snoop_retry = 1'b0; sack_valid = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Lookup on an empty array misses
    req_valid = 1'b1; req_vpn = 28'h123; req_id = 5'd3;
    #1 chk("req_retry_idle", 64'(req_retry), 64'(0));
    tick(); req_valid = 1'b0; #1;
    chk_ack("miss_empty", 5'd3, 1'b0, 28'h0);
    chk("miss_empty_snoop", 64'(snoop_valid), 64'(0));
    tick();
    chk("ack_drain", 64'(ack_valid), 64'(0));

    // Fill then hit, then in-place update
    fill_valid = 1'b1; fill_vpn = 28'h10; fill_ppn = 28'hAB;
    tick(); fill_valid = 1'b0; #1;
    chk("fill1_fill_retry", 64'(fill_retry), 64'(0));
    req_valid = 1'b1; req_vpn = 28'h10; req_id = 5'd7;
    tick(); req_valid = 1'b0; #1;
    chk_ack("hit_ab", 5'd7, 1'b1, 28'hAB);
    fill_valid = 1'b1; fill_vpn = 28'h10; fill_ppn = 28'hCD;
    tick(); fill_valid = 1'b0; #1;
    chk("refill_snoop", 64'(snoop_valid), 64'(0));
    chk("refill_fill_retry", 64'(fill_retry), 64'(0));
    req_valid = 1'b1; req_vpn = 28'h10; req_id = 5'd8;
    tick(); req_valid = 1'b0; #1;
    chk_ack("hit_cd", 5'd8, 1'b1, 28'hCD);

    // Eviction snoop: start from an empty array
    reset = 1'b1; tick(); reset = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      fill_valid = 1'b1; fill_vpn = VPN_W'(v); fill_ppn = PPN_W'(32'h100 + v);
      tick();
    end
    chk("full_no_snoop", 64'(snoop_valid), 64'(0));
    fill_vpn = 28'h9; fill_ppn = 28'h109;
    tick(); fill_valid = 1'b0; snoop_retry = 1'b1; #1;
    chk("evict_snoop_valid", 64'(snoop_valid), 64'(1));
    chk("evict_snoop_vpn", 64'(snoop_vpn), 64'(1));
    chk("evict_fill_retry", 64'(fill_retry), 64'(1));
    req_valid = 1'b1; req_vpn = 28'h9; req_id = 5'd9;
    for (int k = 0; k < 3; k++) begin
      tick(); req_valid = 1'b0; #1;
      chk("held_snoop_valid", 64'(snoop_valid), 64'(1));
      chk("held_snoop_vpn", 64'(snoop_vpn), 64'(1));
      chk("held_fill_retry", 64'(fill_retry), 64'(1));
      if (k == 0) chk_ack("snoop_lookup_new", 5'd9, 1'b1, 28'h109);
    end
    snoop_retry = 1'b0;
    tick(); #1;
    chk("wait_snoop_valid", 64'(snoop_valid), 64'(0));
    chk("wait_fill_retry", 64'(fill_retry), 64'(1));
    sack_valid = 1'b1;
    tick(); sack_valid = 1'b0; #1;
    chk("sack_fill_retry", 64'(fill_retry), 64'(0));
    chk("sack_no_err", 64'(sack_err), 64'(0));
    req_valid = 1'b1; req_vpn = 28'h1; req_id = 5'd10;
    tick(); req_vpn = 28'h9; req_id = 5'd11; #1;
    chk_ack("evicted_miss", 5'd10, 1'b0, 28'h0);
    tick(); req_valid = 1'b0; #1;
    chk_ack("new_hit", 5'd11, 1'b1, 28'h109);
    tick();

    // Ack backpressure and back-to-back acks
    req_valid = 1'b1; req_vpn = 28'h2; req_id = 5'd1;
    tick(); req_vpn = 28'h3; req_id = 5'd2; ack_retry = 1'b1; #1;
    chk("bp_req_retry", 64'(req_retry), 64'(1));
    chk_ack("bp_ack0", 5'd1, 1'b1, 28'h102);
    repeat (2) begin
      tick();
      chk("bp_req_retry_hold", 64'(req_retry), 64'(1));
      chk_ack("bp_ack_hold", 5'd1, 1'b1, 28'h102);
    end
    ack_retry = 1'b0; #1;
    chk("bp_release_req_retry", 64'(req_retry), 64'(0));
    tick(); req_vpn = 28'h4; req_id = 5'd4; #1;
    chk_ack("bp_next", 5'd2, 1'b1, 28'h103);
    tick(); req_valid = 1'b0; #1;
    chk_ack("b2b", 5'd4, 1'b1, 28'h104);
    tick();
    chk("b2b_drain", 64'(ack_valid), 64'(0));

    // Same-cycle request and fill of a new VPN (evicts entry 1 = vpn 0x2)
    req_valid = 1'b1; req_vpn = 28'h20; req_id = 5'd5;
    fill_valid = 1'b1; fill_vpn = 28'h20; fill_ppn = 28'h220;
    tick(); fill_valid = 1'b0; req_id = 5'd6; #1;
    chk_ack("same_cycle_miss", 5'd5, 1'b0, 28'h0);
    chk("same_cycle_snoop_vpn", 64'(snoop_vpn), 64'(2));
    tick(); req_valid = 1'b0; #1;
    chk_ack("same_cycle_next_hit", 5'd6, 1'b1, 28'h220);
    chk("same_cycle_wait", 64'(snoop_valid), 64'(0));

    // Sack in WAIT_SACK is clean; a stray sack in IDLE sets the sticky error
    sack_valid = 1'b1;
    tick(); #1;
    chk("ok_sack_err", 64'(sack_err), 64'(0));
    chk("ok_sack_fill_retry", 64'(fill_retry), 64'(0));
    tick(); sack_valid = 1'b0; #1;
    chk("stray_sack_err", 64'(sack_err), 64'(1));
    chk("stray_fill_retry", 64'(fill_retry), 64'(0));
    chk("stray_snoop_valid", 64'(snoop_valid), 64'(0));
    tick();
    chk("stray_sticky", 64'(sack_err), 64'(1));

    // Reset during WAIT_SACK (fill evicts entry 2 = vpn 0x3)
    fill_valid = 1'b1; fill_vpn = 28'h30; fill_ppn = 28'h330;
    tick(); fill_valid = 1'b0; #1;
    chk("rst_snoop_vpn", 64'(snoop_vpn), 64'(3));
    tick(); #1;
    chk("rst_wait_fill_retry", 64'(fill_retry), 64'(1));
    reset = 1'b1; #1;
    chk_all_zero("midsnoop_reset");
    tick(); reset = 1'b0;
    req_valid = 1'b1; req_vpn = 28'h9; req_id = 5'd12;
    tick(); req_valid = 1'b0; #1;
    chk_ack("post_reset_empty", 5'd12, 1'b0, 28'h0);
    fill_valid = 1'b1; fill_vpn = 28'h40; fill_ppn = 28'h440;
    #1 chk("post_reset_fill_retry", 64'(fill_retry), 64'(0));
    tick(); fill_valid = 1'b0; #1;
    chk("post_reset_no_snoop", 64'(snoop_valid), 64'(0));
    req_valid = 1'b1; req_vpn = 28'h40; req_id = 5'd13;
    tick(); req_valid = 1'b0; #1;
    chk_ack("post_reset_hit", 5'd13, 1'b1, 28'h440);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2tlb_l1port.md
# l2tlb_l1port

L2-TLB-side port that terminates one L1 TLB's valid/retry channels: it answers `l1tlbtol2tlb_req` lookups with `l2tlbtol1tlb_ack`, and it keeps the L1 inclusive. When a page-walker fill evicts a valid entry, the port sends an `l2tlbtol1tlb_snoop` and waits for the matching `l1tlbtol2tlb_sack`. It holds a small fully-associative translation array and sits between the L2 TLB page walker and the `ictlb`/`dctlb` L1 interfaces.

## Interface
- `ENTRIES`, 8: translation entries (power of 2, ≥2).
- `VPN_W`, 28: virtual page number width.
- `PPN_W`, 28: physical page number width.
- `ID_W`, 5: request tag width.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `l1tlbtol2tlb_req_valid` in 1 / `l1tlbtol2tlb_req_retry` out 1: L1 lookup request handshake.
- `l1tlbtol2tlb_req_vpn` in VPN_W: VPN to translate.
- `l1tlbtol2tlb_req_id` in ID_W: request tag.
- `l2tlbtol1tlb_ack_valid` out 1 / `l2tlbtol1tlb_ack_retry` in 1: lookup response handshake.
- `l2tlbtol1tlb_ack_id` out ID_W: echoed tag.
- `l2tlbtol1tlb_ack_hit` out 1: 1 = translation found, 0 = miss.
- `l2tlbtol1tlb_ack_ppn` out PPN_W: PPN on hit, 0 on miss.
- `ptwtol2tlb_fill_valid` in 1 / `ptwtol2tlb_fill_retry` out 1: page-walker fill handshake.
- `ptwtol2tlb_fill_vpn` in VPN_W / `ptwtol2tlb_fill_ppn` in PPN_W: translation to install.
- `l2tlbtol1tlb_snoop_valid` out 1 / `l2tlbtol1tlb_snoop_retry` in 1: eviction snoop to L1.
- `l2tlbtol1tlb_snoop_vpn` out VPN_W: evicted VPN.
- `l1tlbtol2tlb_sack_valid` in 1 / `l1tlbtol2tlb_sack_retry` out 1: snoop acknowledge; retry is tied to 0.
- `sack_err` out 1: sticky; set when a sack arrives outside WAIT_SACK.

## Operation
- **Handshake.** A transfer occurs on a cycle with valid=1 and retry=0. A sender holds valid and payload stable until the transfer.
- **Lookup.**
  - Request accepted when `req_retry`=0, where `req_retry = ack_valid & ack_retry`.
  - The lookup compares the VPN against all valid entries using the array state at the start of the cycle.
  - The result is registered into the ack slot.
  - At most one entry matches, guaranteed by the fill rules.
- **Ack slot.** One entry. It is loaded on request acceptance and cleared on ack transfer. If a transfer and a new acceptance happen in the same cycle, the slot is reloaded (valid stays 1).
- **Fill.** Accepted when `fill_retry`=0, where `fill_retry = (snoop FSM != IDLE)`. The entry is written at the acceptance edge. Target selection, in priority order:
  - A valid entry with the same VPN: update its PPN in place; no snoop.
  - Otherwise, the lowest-index invalid entry; no snoop.
  - Otherwise, the entry at round-robin `victim_ptr`. Its old VPN is latched into the snoop register, and `victim_ptr` advances by 1 mod ENTRIES. The FSM goes to SNOOP.
- **Snoop FSM.**
  - IDLE → SNOOP on a fill that evicts a valid entry.
  - SNOOP: `snoop_valid`=1. Goes to WAIT_SACK on snoop transfer.
  - WAIT_SACK: goes to IDLE on `sack_valid`=1.
  - `sack_valid` in IDLE or SNOOP is dropped and sets `sack_err`.
- **Concurrency.**
  - Lookups continue during SNOOP and WAIT_SACK, and see the new entry; the evicted VPN misses.
  - When a request and a fill are accepted in the same cycle, the lookup sees pre-fill contents.
- **Reset.**
  - All entries invalid; `victim_ptr`=0; FSM in IDLE; ack slot empty.
  - All outputs 0, including `sack_err`, `req_retry`, and `fill_retry`.
  - Reset asserted mid-snoop abandons the snoop; no sack is expected afterwards.

## Timing
- Lookup latency: request accepted at edge N → `ack_valid`=1 after edge N, visible in cycle N+1.
- Throughput: 1 request/cycle while `ack_retry`=0.
- `req_retry` is combinational from `ack_valid` and `ack_retry`, so there is no bubble when the ack drains.
- Fill with eviction accepted at edge N → `snoop_valid`=1 in cycle N+1.
- `fill_retry`=1 from cycle N+1 until the cycle after the sack edge.
- Minimum fill-to-next-fill spacing with eviction is 3 cycles: fill, snoop transfer, sack.
- `sack_retry` is always 0.
- Ack and snoop payloads are registered and do not change while valid=1 and retry=1.

## Test plan
- **Reset then lookup.** Reset, then request vpn=0x123, id=3 → next cycle `ack_valid`=1, hit=0, ppn=0, id=3; `snoop_valid`=0.
- **Fill then hit, with in-place update.**
  - Fill vpn=0x10 ppn=0xAB → request vpn=0x10 id=7 → ack hit=1, ppn=0xAB, id=7.
  - Refill vpn=0x10 ppn=0xCD → next lookup returns 0xCD, no snoop.
- **Eviction snoop.**
  - Fill 8 distinct VPNs 0x1..0x8, then a 9th fill vpn=0x9 → `snoop_valid`=1 with vpn=0x1.
  - Hold `snoop_retry`=1 for 3 cycles → payload stable and `fill_retry`=1 throughout.
  - Release, then sack → `fill_retry`=0; lookup of 0x1 misses and lookup of 0x9 hits.
- **Ack backpressure.**
  - Hold `ack_retry`=1 with ack pending → `req_retry`=1 and ack payload stable.
  - Release while a new request is valid → the ack transfers and the new request is accepted in the same cycle.
  - Back-to-back acks, no bubble.
- **Same-cycle request and fill** of the same new VPN → the ack misses; the next request hits.
- **Stray sack and reset mid-snoop.**
  - Sack in IDLE → `sack_err`=1 and the FSM is unchanged.
  - Assert reset during WAIT_SACK → all outputs 0, array empty, and a following fill is accepted with no snoop.
